// File: rtl/uart_packet_rx_pkg.sv
// Shared constants and state encoding for the UART packet receiver.
package uart_pkt_pkg;

    localparam logic [7:0] START = 8'hFF;
    localparam logic [7:0] TRAIN = 8'hF0;
    localparam logic [7:0] TEST  = 8'h0F;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MODE  = 3'd1,
        S_LABEL = 3'd2,
        S_DATA  = 3'd3,
        S_CHECK = 3'd4
    } state_e;

endpackage

// File: rtl/uart_packet_rx_if.sv
// Byte stream from the UART sampler and result pulses towards the control unit.
interface uart_packet_rx_if;

    logic       data_rdy;
    logic [7:0] uart_byte;
    logic       start;
    logic       train;
    logic       resend;
    logic       pkt_err;
    logic       timeout_err;
    logic [7:0] label;

    modport master (
        output data_rdy, uart_byte,
        input  start, train, resend, pkt_err, timeout_err, label
    );

    modport slave (
        input  data_rdy, uart_byte,
        output start, train, resend, pkt_err, timeout_err, label
    );

endinterface

// File: rtl/uart_packet_rx_ones_comp_add.sv
// 8-bit one's-complement adder: binary sum with the carry folded back into bit 0.
module ones_comp_add (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    output logic [7:0] sum_o
);

    logic [8:0] raw_s;

    // The wrapped carry cannot overflow again: 0xFE + 1 is the worst case.
    always_comb begin
        raw_s = {1'b0, a_i} + {1'b0, b_i};
        sum_o = raw_s[7:0] + {7'b0, raw_s[8]};
    end

endmodule

// File: rtl/uart_packet_rx.sv
// Frames START/MODE/LABEL/PIXELS/CHECKSUM packets, assembles the image and
// reports good, resend, dropped and timed-out packets as single-cycle pulses.
module uart_packet_rx
    import uart_pkt_pkg::*;
#(
    parameter int PIX_CNT     = 784,
    parameter int PIX_W       = 8,
    parameter int NUM_CLASSES = 10,
    parameter int TIMEOUT_CYC = 2048,
    parameter int MAX_RETRY   = 1
) (
    input  logic                             uart_sampling_clk,
    input  logic                             rst_n,
    uart_packet_rx_if.slave                  pkt_if,
    output logic [2:0]                       cs_out,
    output logic [$clog2(PIX_CNT+1)-1:0]     data_count,
    output logic [PIX_CNT*PIX_W-1:0]         image
);

    localparam int IMG_W   = PIX_CNT * PIX_W;
    localparam int CNT_W   = $clog2(PIX_CNT + 1);
    localparam int TMR_W   = $clog2(TIMEOUT_CYC);
    localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [8:0] NUM_CLASSES_L = 9'(NUM_CLASSES);

    state_e               state_q,        state_d;
    logic                 mode_q,         mode_d;
    logic                 bad_label_q,    bad_label_d;
    logic [7:0]           label_shadow_q, label_shadow_d;
    logic [7:0]           label_q,        label_d;
    logic [7:0]           checksum_q,     checksum_d;
    logic [CNT_W-1:0]     data_count_q,   data_count_d;
    logic [RETRY_W-1:0]   retry_q,        retry_d;
    logic [TMR_W-1:0]     timer_q,        timer_d;
    logic [IMG_W-1:0]     image_q,        image_d;
    logic                 start_q,        start_d;
    logic                 train_q,        train_d;
    logic                 resend_q,       resend_d;
    logic                 pkt_err_q,      pkt_err_d;
    logic                 timeout_q,      timeout_d;
    logic [7:0]           cksum_sum_s;

    ones_comp_add u_cksum_add (
        .a_i   (checksum_q),
        .b_i   (pkt_if.uart_byte),
        .sum_o (cksum_sum_s)
    );

    // Next-state logic: byte handling when data_rdy, idle timer otherwise.
    always_comb begin
        state_d        = state_q;
        mode_d         = mode_q;
        bad_label_d    = bad_label_q;
        label_shadow_d = label_shadow_q;
        label_d        = label_q;
        checksum_d     = checksum_q;
        data_count_d   = data_count_q;
        retry_d        = retry_q;
        timer_d        = timer_q;
        image_d        = image_q;
        start_d        = 1'b0;
        train_d        = 1'b0;
        resend_d       = 1'b0;
        pkt_err_d      = 1'b0;
        timeout_d      = 1'b0;

        if (pkt_if.data_rdy) begin
            timer_d = '0;
            case (state_q)
                S_IDLE: begin
                    if (pkt_if.uart_byte == START) begin
                        state_d      = S_MODE;
                        checksum_d   = 8'h00;
                        data_count_d = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_MODE: begin
                    if (pkt_if.uart_byte == TRAIN) begin
                        state_d = S_LABEL;
                        mode_d  = 1'b1;
                    end else if (pkt_if.uart_byte == TEST) begin
                        state_d = S_LABEL;
                        mode_d  = 1'b0;
                    end else if (pkt_if.uart_byte == START) begin
                        state_d = S_MODE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_LABEL: begin
                    label_shadow_d = pkt_if.uart_byte;
                    checksum_d     = cksum_sum_s;
                    image_d        = '0;
                    bad_label_d    = mode_q && ({1'b0, pkt_if.uart_byte} >= NUM_CLASSES_L);
                    state_d        = S_DATA;
                end
                S_DATA: begin
                    // Newest pixel enters at the top so pixel 0 ends up in the LSBs.
                    image_d = image_q >> PIX_W;
                    image_d[IMG_W-1 -: PIX_W] = pkt_if.uart_byte[PIX_W-1:0];
                    checksum_d   = cksum_sum_s;
                    data_count_d = data_count_q + CNT_W'(1);
                    if (data_count_q == CNT_W'(PIX_CNT - 1)) begin
                        state_d = S_CHECK;
                    end else begin
                        state_d = S_DATA;
                    end
                end
                S_CHECK: begin
                    state_d = S_IDLE;
                    if (bad_label_q) begin
                        pkt_err_d = 1'b1;
                        retry_d   = '0;
                    end else if (pkt_if.uart_byte == checksum_q) begin
                        start_d = 1'b1;
                        train_d = mode_q;
                        label_d = label_shadow_q;
                        retry_d = '0;
                    end else if (retry_q < RETRY_W'(MAX_RETRY)) begin
                        resend_d = 1'b1;
                        retry_d  = retry_q + RETRY_W'(1);
                    end else begin
                        pkt_err_d = 1'b1;
                        retry_d   = '0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end else if (state_q != S_IDLE) begin
            if (timer_q == TMR_W'(TIMEOUT_CYC - 1)) begin
                timeout_d = 1'b1;
                state_d   = S_IDLE;
                retry_d   = '0;
                timer_d   = '0;
            end else begin
                timer_d = timer_q + TMR_W'(1);
            end
        end else begin
            timer_d = timer_q;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge uart_sampling_clk) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            mode_q         <= 1'b0;
            bad_label_q    <= 1'b0;
            label_shadow_q <= 8'h00;
            label_q        <= 8'h00;
            checksum_q     <= 8'h00;
            data_count_q   <= '0;
            retry_q        <= '0;
            timer_q        <= '0;
            image_q        <= '0;
            start_q        <= 1'b0;
            train_q        <= 1'b0;
            resend_q       <= 1'b0;
            pkt_err_q      <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            mode_q         <= mode_d;
            bad_label_q    <= bad_label_d;
            label_shadow_q <= label_shadow_d;
            label_q        <= label_d;
            checksum_q     <= checksum_d;
            data_count_q   <= data_count_d;
            retry_q        <= retry_d;
            timer_q        <= timer_d;
            image_q        <= image_d;
            start_q        <= start_d;
            train_q        <= train_d;
            resend_q       <= resend_d;
            pkt_err_q      <= pkt_err_d;
            timeout_q      <= timeout_d;
        end
    end

    assign cs_out             = state_q;
    assign data_count         = data_count_q;
    assign image              = image_q;
    assign pkt_if.start       = start_q;
    assign pkt_if.train       = train_q;
    assign pkt_if.resend      = resend_q;
    assign pkt_if.pkt_err     = pkt_err_q;
    assign pkt_if.timeout_err = timeout_q;
    assign pkt_if.label       = label_q;

endmodule

// File: tb/tb_uart_packet_rx.sv
// Scoreboard bench: full-size receiver plus a 4-pixel, 4-bit, no-retry receiver.
module tb_uart_packet_rx;
    import uart_pkt_pkg::*;

    localparam int PIX_A = 784;
    localparam int IMG_A = PIX_A * 8;
    localparam int TO_A  = 2048;
    localparam int PIX_B = 4;
    localparam int IMG_B = 16;
    localparam int TO_B  = 16;

    // pulses = {start, resend, pkt_err, timeout_err}
    typedef struct {
        logic [3:0]       pulses;
        logic             train;
        logic [7:0]       label;
        logic [IMG_A-1:0] image;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n_a, rst_n_b;
    logic [2:0]       cs_a, cs_b;
    logic [9:0]       cnt_a;
    logic [2:0]       cnt_b;
    logic [IMG_A-1:0] img_a;
    logic [IMG_B-1:0] img_b;

    uart_packet_rx_if ifa ();
    uart_packet_rx_if ifb ();

    uart_packet_rx #(.PIX_CNT(PIX_A), .PIX_W(8), .NUM_CLASSES(10), .TIMEOUT_CYC(TO_A), .MAX_RETRY(1)) dut_a (
        .uart_sampling_clk (clk),
        .rst_n             (rst_n_a),
        .pkt_if            (ifa),
        .cs_out            (cs_a),
        .data_count        (cnt_a),
        .image             (img_a)
    );

    uart_packet_rx #(.PIX_CNT(PIX_B), .PIX_W(4), .NUM_CLASSES(10), .TIMEOUT_CYC(TO_B), .MAX_RETRY(0)) dut_b (
        .uart_sampling_clk (clk),
        .rst_n             (rst_n_b),
        .pkt_if            (ifb),
        .cs_out            (cs_b),
        .data_count        (cnt_b),
        .image             (img_b)
    );

    exp_t       qa[$];
    exp_t       qb[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] pix_a [PIX_A];
    logic [IMG_A-1:0] exp_img;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_a(input logic [3:0] p, input logic tr, input logic [7:0] lb, input logic [IMG_A-1:0] im);
        exp_t e;
        e.pulses = p; e.train = tr; e.label = lb; e.image = im;
        qa.push_back(e);
    endtask

    task automatic push_b(input logic [3:0] p, input logic tr, input logic [7:0] lb, input logic [IMG_B-1:0] im);
        exp_t e;
        e.pulses = p; e.train = tr; e.label = lb; e.image = IMG_A'(im);
        qb.push_back(e);
    endtask

    task automatic send_a(input logic [7:0] b);
        ifa.data_rdy  = 1'b1;
        ifa.uart_byte = b;
        @(negedge clk);
        ifa.data_rdy  = 1'b0;
        ifa.uart_byte = 8'h00;
    endtask

    task automatic send_b(input logic [7:0] b);
        ifb.data_rdy  = 1'b1;
        ifb.uart_byte = b;
        @(negedge clk);
        ifb.data_rdy  = 1'b0;
        ifb.uart_byte = 8'h00;
    endtask

    task automatic send_pkt_a(input logic [7:0] mode, input logic [7:0] lb, input logic [7:0] cks);
        send_a(START);
        send_a(mode);
        send_a(lb);
        for (int i = 0; i < PIX_A; i++) send_a(pix_a[i]);
        send_a(cks);
    endtask

    task automatic send_pkt_b(input logic [7:0] lb, input logic [7:0] cks);
        send_b(START);
        send_b(TRAIN);
        send_b(lb);
        send_b(8'hA1); send_b(8'hB2); send_b(8'hC3); send_b(8'hD4);
        send_b(cks);
    endtask

    // Monitor for the full-size receiver
    initial begin
        exp_t       e;
        logic [4:0] p;
        int         bad;
        forever begin
            @(negedge clk);
            p = {ifa.start, ifa.resend, ifa.pkt_err, ifa.timeout_err, ifa.train};
            if (p != 5'b0) begin
                if (qa.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL a_unexpected: pulses %b, expected none", p);
                end else begin
                    e = qa.pop_front();
                    chk("a_pulses", 64'(p[4:1]), 64'(e.pulses));
                    chk("a_train", 64'(ifa.train), 64'(e.train));
                    chk("a_label", 64'(ifa.label), 64'(e.label));
                    if (e.pulses[3]) begin
                        bad = -1;
                        for (int i = 0; i < PIX_A; i++)
                            if (bad < 0 && img_a[i*8 +: 8] !== e.image[i*8 +: 8]) bad = i;
                        checks++;
                        if (bad >= 0) begin
                            errors++;
                            $display("FAIL a_image: pixel %0d got 0x%0h, expected 0x%0h",
                                     bad, img_a[bad*8 +: 8], e.image[bad*8 +: 8]);
                        end
                    end
                end
            end
        end
    end

    // Monitor for the small receiver
    initial begin
        exp_t       e;
        logic [4:0] p;
        forever begin
            @(negedge clk);
            p = {ifb.start, ifb.resend, ifb.pkt_err, ifb.timeout_err, ifb.train};
            if (p != 5'b0) begin
                if (qb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL b_unexpected: pulses %b, expected none", p);
                end else begin
                    e = qb.pop_front();
                    chk("b_pulses", 64'(p[4:1]), 64'(e.pulses));
                    chk("b_train", 64'(ifb.train), 64'(e.train));
                    chk("b_label", 64'(ifb.label), 64'(e.label));
                    if (e.pulses[3]) chk("b_image", 64'(img_b), 64'(e.image[IMG_B-1:0]));
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n_a = 1'b0; rst_n_b = 1'b0;
        ifa.data_rdy = 1'b0; ifa.uart_byte = 8'h00;
        ifb.data_rdy = 1'b0; ifb.uart_byte = 8'h00;
        repeat (3) @(negedge clk);
        rst_n_a = 1'b1; rst_n_b = 1'b1;
        @(negedge clk);

        chk("a_reset_cs", 64'(cs_a), 64'd0);
        chk("a_reset_count", 64'(cnt_a), 64'd0);
        chk("a_reset_image_nonzero", 64'(img_a != '0), 64'd0);
        chk("a_reset_label", 64'(ifa.label), 64'd0);
        chk("a_reset_pulses", 64'({ifa.start, ifa.train, ifa.resend, ifa.pkt_err, ifa.timeout_err}), 64'd0);
        chk("b_reset_cs", 64'(cs_b), 64'd0);
        chk("b_reset_image", 64'(img_b), 64'd0);

        // Good TRAIN packet, label 3, all pixels 1: 3 + 784 = 787 -> 0x16
        for (int i = 0; i < PIX_A; i++) begin pix_a[i] = 8'h01; exp_img[i*8 +: 8] = 8'h01; end
        push_a(4'b1000, 1'b1, 8'h03, exp_img);
        send_a(START); send_a(TRAIN); send_a(8'h03);
        for (int i = 0; i < PIX_A; i++) send_a(pix_a[i]);
        chk("a_full_count", 64'(cnt_a), 64'd784);
        chk("a_check_state", 64'(cs_a), 64'd4);
        send_a(8'h16);
        repeat (2) @(negedge clk);
        chk("a_idle_after_good", 64'(cs_a), 64'd0);

        // Bad checksum twice: resend, then drop
        push_a(4'b0100, 1'b0, 8'h03, '0);
        send_pkt_a(TRAIN, 8'h03, 8'h00);
        push_a(4'b0010, 1'b0, 8'h03, '0);
        send_pkt_a(TRAIN, 8'h03, 8'h00);
        repeat (2) @(negedge clk);
        chk("a_idle_after_drop", 64'(cs_a), 64'd0);

        // Label 10 out of range in TRAIN: 10 + 784 = 794 -> 0x1D
        push_a(4'b0010, 1'b0, 8'h03, '0);
        send_pkt_a(TRAIN, 8'h0A, 8'h1D);
        repeat (2) @(negedge clk);

        // Idle timeout mid-packet
        push_a(4'b0001, 1'b0, 8'h03, '0);
        send_a(START); send_a(TEST); send_a(8'h05);
        repeat (TO_A + 4) @(negedge clk);
        chk("a_timeout_cs", 64'(cs_a), 64'd0);

        // Byte arriving in the expiry cycle prevents the timeout
        send_a(START); send_a(TEST); send_a(8'h05);
        repeat (TO_A - 1) @(negedge clk);
        send_a(8'h01);
        chk("a_expiry_saved_cs", 64'(cs_a), 64'd3);
        chk("a_expiry_saved_count", 64'(cnt_a), 64'd1);
        push_a(4'b0001, 1'b0, 8'h03, '0);
        repeat (TO_A + 4) @(negedge clk);
        chk("a_timeout2_cs", 64'(cs_a), 64'd0);

        // Garbage + resync, TEST label 12 (not range checked), pixel i = i mod 256 -> 0x84
        for (int i = 0; i < PIX_A; i++) begin pix_a[i] = 8'(i); exp_img[i*8 +: 8] = 8'(i); end
        push_a(4'b1000, 1'b0, 8'h0C, exp_img);
        send_a(8'h12);
        chk("a_garbage_ignored", 64'(cs_a), 64'd0);
        send_a(START); send_a(START);
        chk("a_resync_mode", 64'(cs_a), 64'd1);
        send_a(TEST); send_a(8'h0C);
        for (int i = 0; i < PIX_A; i++) send_a(pix_a[i]);
        send_a(8'h84);
        send_a(8'h12);
        send_a(START);
        chk("a_mode_after_ff", 64'(cs_a), 64'd1);
        send_a(8'h55);
        chk("a_bad_mode_idle", 64'(cs_a), 64'd0);

        // Reset during data byte 400
        for (int i = 0; i < PIX_A; i++) begin pix_a[i] = 8'h02; exp_img[i*8 +: 8] = 8'h02; end
        send_a(START); send_a(TRAIN); send_a(8'h07);
        for (int i = 0; i < 399; i++) send_a(pix_a[i]);
        rst_n_a = 1'b0; ifa.data_rdy = 1'b1; ifa.uart_byte = 8'h02;
        @(negedge clk);
        rst_n_a = 1'b1; ifa.data_rdy = 1'b0; ifa.uart_byte = 8'h00;
        chk("a_midrst_cs", 64'(cs_a), 64'd0);
        chk("a_midrst_count", 64'(cnt_a), 64'd0);
        chk("a_midrst_image_nonzero", 64'(img_a != '0), 64'd0);
        chk("a_midrst_label", 64'(ifa.label), 64'd0);
        // label 7 + 784*2 = 1575 -> 0x2D
        push_a(4'b1000, 1'b1, 8'h07, exp_img);
        send_pkt_a(TRAIN, 8'h07, 8'h2D);

        // Small receiver: 2 + A1 + B2 + C3 + D4 = 748 -> 0xEE; low nibbles pack to 0x4321
        push_b(4'b1000, 1'b1, 8'h02, 16'h4321);
        send_pkt_b(8'h02, 8'hEE);
        push_b(4'b0010, 1'b0, 8'h02, 16'h0000);
        send_pkt_b(8'h02, 8'h00);
        repeat (2) @(negedge clk);
        chk("b_idle_after_drop", 64'(cs_b), 64'd0);
        push_b(4'b0001, 1'b0, 8'h02, 16'h0000);
        send_b(START); send_b(TRAIN);
        repeat (TO_B + 4) @(negedge clk);
        chk("b_timeout_cs", 64'(cs_b), 64'd0);

        repeat (10) @(negedge clk);
        checks++;
        if (qa.size() != 0) begin
            errors++;
            $display("FAIL a_missing: %0d expected pulses never seen", qa.size());
        end
        checks++;
        if (qb.size() != 0) begin
            errors++;
            $display("FAIL b_missing: %0d expected pulses never seen", qb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
